// File: rtl/flopoco_fp_pkg.sv
// Shared constants and word layout for the FloPoCo (wE=4, wF=4) float format.
package flopoco_fp_pkg;
  localparam int WE   = 4;
  localparam int WF   = 4;
  localparam int BIAS = 7;

  localparam logic [1:0] EXN_ZERO = 2'b00;
  localparam logic [1:0] EXN_NORM = 2'b01;
  localparam logic [1:0] EXN_INF  = 2'b10;
  localparam logic [1:0] EXN_NAN  = 2'b11;

  typedef struct packed {
    logic [1:0]    exn;
    logic          sign;
    logic [WE-1:0] exp;
    logic [WF-1:0] frac;
  } fp_word_t;
endpackage

// File: rtl/fp_round_norm.sv
// Normalizes the 5x5 significand product, rounds to nearest-even and range-checks
// the exponent, yielding the exn/exp/frac of a normal-path result.
module fp_round_norm
  import flopoco_fp_pkg::*;
(
  input  logic [2*WF+1:0]  p,
  input  logic signed [6:0] esum,
  output logic [1:0]       exn,
  output logic [WE-1:0]    exp,
  output logic [WF-1:0]    frac
);
  logic          norm, guard, sticky, up, carry;
  logic [WF-1:0] fr, fr_r;
  logic signed [6:0] e;

  always_comb begin
    norm   = p[9];
    fr     = norm ? p[8:5] : p[7:4];
    guard  = norm ? p[4] : p[3];
    sticky = norm ? |p[3:0] : |p[2:0];
    up     = guard & (sticky | fr[0]);
    // A carry out of the fraction wraps it to 0000, which is exactly 1.0 x 2.
    {carry, fr_r} = {1'b0, fr} + {4'b0, up};
    e = esum + 7'(norm) + 7'(carry);
    exn  = EXN_NORM;
    exp  = e[WE-1:0];
    frac = fr_r;
    if (e > 7'sd15) begin
      exn  = EXN_INF;
      exp  = '0;
      frac = '0;
    end else if (e < 7'sd0) begin
      exn  = EXN_ZERO;
      exp  = '0;
      frac = '0;
    end
  end
endmodule

// File: rtl/flopoco_fmul.sv
// FloPoCo (wE=4, wF=4) multiplier, RNE, one registered output stage.
// Optional FMUL_CE_EN adds a clock-enable port ce on the output register.
module flopoco_fmul
  import flopoco_fp_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
`ifdef FMUL_CE_EN
  input  logic        ce,
`endif
  input  logic [10:0] X,
  input  logic [10:0] Y,
  output logic [10:0] R
);
  fp_word_t x, y, r_d;
  logic [9:0] p;
  logic signed [6:0] esum;
  logic [1:0] n_exn;
  logic [WE-1:0] n_exp;
  logic [WF-1:0] n_frac;
  logic xz, yz, xi, yi, xn, yn, is_nan, is_inf, is_zero;

  assign x = X;
  assign y = Y;

  assign xz = (x.exn == EXN_ZERO);
  assign yz = (y.exn == EXN_ZERO);
  assign xi = (x.exn == EXN_INF);
  assign yi = (y.exn == EXN_INF);
  assign xn = (x.exn == EXN_NAN);
  assign yn = (y.exn == EXN_NAN);

  assign is_nan  = xn | yn | (xz & yi) | (xi & yz);
  assign is_inf  = xi | yi;
  assign is_zero = xz | yz;

  assign p    = {1'b1, x.frac} * {1'b1, y.frac};
  assign esum = $signed({3'b0, x.exp}) + $signed({3'b0, y.exp}) - 7'(BIAS);

  fp_round_norm u_rn (
    .p    (p),
    .esum (esum),
    .exn  (n_exn),
    .exp  (n_exp),
    .frac (n_frac)
  );

  always_comb begin
    r_d.sign = x.sign ^ y.sign;
    r_d.exn  = n_exn;
    r_d.exp  = n_exp;
    r_d.frac = n_frac;
    if (is_nan || is_inf || is_zero) begin
      r_d.exn  = is_nan ? EXN_NAN : (is_inf ? EXN_INF : EXN_ZERO);
      r_d.exp  = '0;
      r_d.frac = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)
      R <= '0;
`ifdef FMUL_CE_EN
    else if (ce)
      R <= r_d;
`else
    else
      R <= r_d;
`endif
  end
endmodule

// File: tb/tb_flopoco_fmul.sv
// Self-checking bench for flopoco_fmul: directed corner cases plus random
// back-to-back operands against an integer-arithmetic reference model.
module tb_flopoco_fmul;
  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] X, Y, R;
`ifdef FMUL_CE_EN
  logic        ce;
`endif
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  flopoco_fmul dut (
    .clk   (clk),
    .reset (reset),
`ifdef FMUL_CE_EN
    .ce    (ce),
`endif
    .X     (X),
    .Y     (Y),
    .R     (R)
  );

  task automatic check(input string tag, input logic [10:0] got, input logic [10:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b expected=%b", tag, got, exp);
    end
  endtask

  // Reference: exact integer product of 1.f values, then divide and round half-even.
  function automatic logic [10:0] model(input logic [10:0] a, input logic [10:0] b);
    logic s;
    int ea, eb, m, sh, q, rem, half, e;
    logic [3:0] e4, q4;
    s  = a[8] ^ b[8];
    if (a[10:9] == 2'b11 || b[10:9] == 2'b11 ||
        (a[10:9] == 2'b00 && b[10:9] == 2'b10) || (a[10:9] == 2'b10 && b[10:9] == 2'b00))
      return {2'b11, s, 8'b0};
    if (a[10:9] == 2'b10 || b[10:9] == 2'b10) return {2'b10, s, 8'b0};
    if (a[10:9] == 2'b00 || b[10:9] == 2'b00) return {2'b00, s, 8'b0};
    ea = int'(a[7:4]);
    eb = int'(b[7:4]);
    m  = (16 + int'(a[3:0])) * (16 + int'(b[3:0]));
    sh = (m >= 512) ? 5 : 4;
    q  = m / (1 << sh);
    rem  = m % (1 << sh);
    half = 1 << (sh - 1);
    e  = ea + eb - 7 + (sh - 4);
    if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
    if (q == 32) begin
      q = 16;
      e = e + 1;
    end
    if (e > 15) return {2'b10, s, 8'b0};
    if (e < 0)  return {2'b00, s, 8'b0};
    e4 = e[3:0];
    q4 = q[3:0];
    return {2'b01, s, e4, q4};
  endfunction

  function automatic logic [10:0] rand_word();
    logic [1:0] ex;
    int k;
    k = int'($urandom_range(0, 7));
    ex = (k == 0) ? 2'b00 : (k == 1) ? 2'b10 : (k == 2) ? 2'b11 : 2'b01;
    return {ex, 9'($urandom)};
  endfunction

  localparam int NDIR = 9;
  logic [10:0] dx [NDIR] = '{11'b01_0_1000_0000, 11'b01_1_1000_0000, 11'b01_0_0111_0001,
                             11'b01_0_0111_0001, 11'b01_0_1111_1111, 11'b01_0_0000_0000,
                             11'b00_0_0000_0000, 11'b11_0_0000_0000, 11'b10_0_0000_0000};
  logic [10:0] dy [NDIR] = '{11'b01_0_1000_1000, 11'b01_0_1000_1000, 11'b01_0_0111_1000,
                             11'b01_0_0111_0001, 11'b01_0_1111_1111, 11'b01_0_0000_0000,
                             11'b10_0_0000_0000, 11'b01_0_1000_0000, 11'b01_1_1000_0000};
  logic [10:0] dr [NDIR] = '{11'b01_0_1001_1000, 11'b01_1_1001_1000, 11'b01_0_0111_1010,
                             11'b01_0_0111_0010, 11'b10_0_0000_0000, 11'b00_0_0000_0000,
                             11'b11_0_0000_0000, 11'b11_0_0000_0000, 11'b10_1_0000_0000};

  initial begin
    logic [10:0] pend_exp;
    logic        pend;
    string       pend_tag;
    reset = 1'b0;
`ifdef FMUL_CE_EN
    ce = 1'b1;
`endif
    X = dx[0];
    Y = dy[0];
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_hold", R, 11'b0);
    reset = 1'b1;
    @(negedge clk);
    check("reset_release", R, 11'b01_0_1001_1000);

`ifdef FMUL_CE_EN
    ce = 1'b0;
    X = dx[2];
    Y = dy[2];
    @(negedge clk);
    check("ce_hold", R, 11'b01_0_1001_1000);
    ce = 1'b1;
`endif

    // Directed table, driven back to back: each result checked one cycle later.
    pend = 1'b0;
    pend_exp = '0;
    pend_tag = "";
    for (int i = 0; i < NDIR; i++) begin
      X = dx[i];
      Y = dy[i];
      if (model(dx[i], dy[i]) !== dr[i]) begin
        failures++;
        $display("FAIL model_dir%0d got=%b expected=%b", i, model(dx[i], dy[i]), dr[i]);
      end
      @(negedge clk);
      check($sformatf("dir%0d", i), R, dr[i]);
    end

    for (int i = 0; i < 400; i++) begin
      X = rand_word();
      Y = rand_word();
      if (pend) check(pend_tag, R, pend_exp);
      pend_exp = model(X, Y);
      pend_tag = $sformatf("rnd%0d X=%b Y=%b", i, X, Y);
      pend = 1'b1;
      @(negedge clk);
    end
    check(pend_tag, R, pend_exp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
